// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART receive path: FSM state
//               encoding, parity modes and oversampling positions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state encoding (3 bits)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Oversampling: three samples around mid-bit, decision on the last one
  localparam logic [3:0] SAMPLE_A      = 4'd7;
  localparam logic [3:0] SAMPLE_B      = 4'd8;
  localparam logic [3:0] SAMPLE_C      = 4'd9;
  localparam int         TICKS_PER_BIT = 16;

  // Two-of-three vote used for every bit decision
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_oversampler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampler_if
// Description : Serial input, baud tick and received-word bundle for the
//               UART receiver. master = driver/consumer, slave = receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampler_if #(
  parameter int DATA_BITS = 8
);
  logic                 clk_16bd;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output clk_16bd, rx,
    input  data, valid, frame_err, parity_err, busy
  );

  modport slave (
    input  clk_16bd, rx,
    output data, valid, frame_err, parity_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizers for rx and the 16x-baud tick, a
//               one-clk tick from the rising edge of the synced baud signal,
//               and a falling-edge flag on the synced rx line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic clk_16bd,
  output logic rx_sync,
  output logic rx_fall,
  output logic tick
);

  // [0] first sync stage, [1] synced value, [2] previous synced value
  logic [2:0] rx_q, rx_d;
  logic [2:0] bd_q, bd_d;

  // Shift both lines through their synchronizer/edge pipelines
  always_comb begin
    rx_d = {rx_q[1:0], rx};
    bd_d = {bd_q[1:0], clk_16bd};
  end

  // All stages reset high so neither an rx fall nor a tick appears out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q <= 3'b111;
      bd_q <= 3'b111;
    end else begin
      rx_q <= rx_d;
      bd_q <= bd_d;
    end
  end

  assign rx_sync = rx_q[1];
  assign rx_fall = rx_q[2] & ~rx_q[1];
  assign tick    = bd_q[1] & ~bd_q[2];

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampler
// Description : UART receiver with 16x oversampling and 3-sample majority
//               vote, LSB-first data, optional even/odd parity, one stop bit.
//               Emits one-clk valid / frame_err / parity_err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_oversampler_if.slave   bus
);

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic w_rx_sync, w_rx_fall, w_tick;
  logic w_maj, w_decide, w_wrap, w_exp_par;

  state_t               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 samp_a_q, samp_a_d;
  logic                 samp_b_q, samp_b_d;
  logic                 par_bad_q, par_bad_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx       (bus.rx),
    .clk_16bd (bus.clk_16bd),
    .rx_sync  (w_rx_sync),
    .rx_fall  (w_rx_fall),
    .tick     (w_tick)
  );

  // Third sample is the live synced line at the decision tick
  assign w_maj     = majority3(samp_a_q, samp_b_q, w_rx_sync);
  assign w_decide  = w_tick && (tick_cnt_q == SAMPLE_C);
  assign w_wrap    = w_tick && (tick_cnt_q == LAST_TICK);
  assign w_exp_par = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

  // Next-state logic: edge detection in IDLE, tick-driven bit timing elsewhere
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    samp_a_d     = samp_a_q;
    samp_b_d     = samp_b_q;
    par_bad_d    = par_bad_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    if (state_q == ST_IDLE) begin
      // A coincident tick is ignored; counting starts with the next one
      if (w_rx_fall) begin
        state_d    = ST_START;
        tick_cnt_d = 4'd0;
        par_bad_d  = 1'b0;
      end
    end else if (w_tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q == SAMPLE_A) samp_a_d = w_rx_sync;
      if (tick_cnt_q == SAMPLE_B) samp_b_d = w_rx_sync;

      case (state_q)
        ST_START: begin
          if (w_decide && w_maj) begin
            state_d = ST_IDLE;
          end else if (w_wrap) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end
        end
        ST_DATA: begin
          if (w_decide) shift_d = {w_maj, shift_q[DATA_BITS-1:1]};
          if (w_wrap) begin
            if (bit_idx_q == LAST_BIT)
              state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        ST_PARITY: begin
          if (w_decide) par_bad_d = (w_maj != w_exp_par);
          if (w_wrap)   state_d   = ST_STOP;
        end
        ST_STOP: begin
          // Leave at mid-stop so a new start bit can follow immediately
          if (w_decide) begin
            data_d       = shift_q;
            valid_d      = w_maj;
            frame_err_d  = ~w_maj;
            parity_err_d = par_bad_q;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      data_q       <= '0;
      samp_a_q     <= 1'b1;
      samp_b_q     <= 1'b1;
      par_bad_q    <= 1'b0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
      par_bad_q    <= par_bad_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_oversampler
// Description : Self-checking bench: an 8N1 receiver and an 8E1 receiver
//               driven with directed and random frames; expectations come
//               from a per-frame model (word, stop level, parity count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampler;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_oversampler_if #(.DATA_BITS(8)) if0 ();
  uart_rx_oversampler_if #(.DATA_BITS(8)) if1 ();

  uart_rx_oversampler #(.DATA_BITS(8), .PARITY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_rx_oversampler #(.DATA_BITS(8), .PARITY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int errors = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mdata0 = 8'h00;
  logic [7:0] mdata1 = 8'h00;
  logic       lastp1 = 1'b0;
  logic       lastv1 = 1'b0;
  logic       lv0 = 1'b1;
  logic       lv1 = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: pulses are matched against the frame queue, data must
  // hold the last completed word, parity_err never appears on its own
  always @(negedge clk) begin
    exp_t e;
    if (if0.valid || if0.frame_err) begin
      if (q0.size() == 0) chk("d0_unexpected_pulse", 1, 0);
      else begin
        e = q0.pop_front();
        chk("d0_valid", if0.valid, e.valid);
        chk("d0_frame_err", if0.frame_err, e.ferr);
        chk("d0_parity_err", if0.parity_err, e.perr);
        chk("d0_data", if0.data, e.data);
        mdata0 = e.data;
      end
    end else begin
      chk("d0_lone_parity_err", if0.parity_err, 0);
      chk("d0_data_hold", if0.data, mdata0);
    end
    if (if1.valid || if1.frame_err) begin
      if (q1.size() == 0) chk("d1_unexpected_pulse", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_valid", if1.valid, e.valid);
        chk("d1_frame_err", if1.frame_err, e.ferr);
        chk("d1_parity_err", if1.parity_err, e.perr);
        chk("d1_data", if1.data, e.data);
        mdata1 = e.data;
        lastp1 = if1.parity_err;
        lastv1 = if1.valid;
      end
    end else begin
      chk("d1_lone_parity_err", if1.parity_err, 0);
      chk("d1_data_hold", if1.data, mdata1);
    end
  end

  // One baud tick period (4 clk): lines change together with the tick edge
  task automatic tick1();
    if0.rx = lv0; if1.rx = lv1;
    if0.clk_16bd = 1'b1; if1.clk_16bd = 1'b1;
    @(negedge clk); @(negedge clk);
    if0.clk_16bd = 1'b0; if1.clk_16bd = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic set_line(input int d, input logic v);
    if (d == 0) lv0 = v; else lv1 = v;
  endtask

  task automatic send_level(input int d, input logic v, input int n);
    set_line(d, v);
    repeat (n) tick1();
  endtask

  // One bit period; an optional glitch inverts the tick the receiver sees as tick_cnt 8
  task automatic send_bit(input int d, input logic v, input bit glitch);
    for (int t = 0; t < 16; t++) begin
      set_line(d, (glitch && t == 9) ? ~v : v);
      tick1();
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] w, input logic pbit,
                            input logic stop, input int gbit, input int stop_ticks);
    exp_t e;
    e.data  = w;
    e.valid = stop;
    e.ferr  = ~stop;
    e.perr  = (d == 1) ? ((($countones(w) + int'(pbit)) % 2) != 0) : 1'b0;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    send_bit(d, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d, w[i], gbit == i);
    if (d == 1) send_bit(d, pbit, 1'b0);
    send_level(d, stop, stop_ticks);
  endtask

  task automatic chk_drained(input string name);
    chk(name, q0.size() + q1.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    if0.rx = 1'b1; if1.rx = 1'b1;
    if0.clk_16bd = 1'b0; if1.clk_16bd = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", if0.data, 0);
    chk("rst_valid", if0.valid, 0);
    chk("rst_frame_err", if0.frame_err, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_busy1", if1.busy, 0);
    rst = 1'b1;
    send_level(0, 1'b1, 4);

    // 0xA5 8N1 with exact output latency and busy falling at mid-stop
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1, 10);
    if0.clk_16bd = 1'b1; if1.clk_16bd = 1'b1;
    @(negedge clk);
    chk("a5_lat_n1_valid", if0.valid, 0);
    chk("a5_lat_n1_busy", if0.busy, 1);
    @(negedge clk);
    if0.clk_16bd = 1'b0; if1.clk_16bd = 1'b0;
    chk("a5_lat_n2_valid", if0.valid, 0);
    @(negedge clk);
    chk("a5_lat_n3_valid", if0.valid, 1);
    chk("a5_lat_n3_busy", if0.busy, 0);
    @(negedge clk);
    chk("a5_pulse_width", if0.valid, 0);
    send_level(0, 1'b1, 5);
    chk("a5_data_lit", if0.data, 32'hA5);
    chk_drained("a5_drained");

    // False start: low for 4 ticks only
    send_level(0, 1'b0, 4);
    chk("fs_busy_high", if0.busy, 1);
    send_level(0, 1'b1, 20);
    chk("fs_busy_low", if0.busy, 0);
    chk("fs_data_kept", if0.data, 32'hA5);

    // 0x3C with stop held low, line stays low: no restart without a new fall
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1, 16);
    send_level(0, 1'b0, 40);
    chk("fe_no_restart", if0.busy, 0);
    chk("fe_data_lit", if0.data, 32'h3C);
    send_level(0, 1'b1, 20);
    send_frame(0, 8'h5A, 1'b0, 1'b1, -1, 16);
    chk("after_fe_data_lit", if0.data, 32'h5A);

    // Even parity, 0x03: parity bit 1 is wrong, 0 is right
    send_level(1, 1'b1, 4);
    send_frame(1, 8'h03, 1'b1, 1'b1, -1, 16);
    chk("par03_bad_perr_lit", lastp1, 1);
    chk("par03_bad_valid_lit", lastv1, 1);
    send_frame(1, 8'h03, 1'b0, 1'b1, -1, 16);
    chk("par03_good_perr_lit", lastp1, 0);

    // Back-to-back frames
    send_frame(0, 8'h00, 1'b0, 1'b1, -1, 16);
    chk("b2b_first_lit", if0.data, 32'h00);
    send_frame(0, 8'hFF, 1'b0, 1'b1, -1, 16);
    chk("b2b_second_lit", if0.data, 32'hFF);

    // Glitch on a data bit of 0x55
    send_frame(0, 8'h55, 1'b0, 1'b1, 3, 16);
    chk("glitch_data_lit", if0.data, 32'h55);

    // Reset during bit 4 abandons the frame
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, i[0], 1'b0);
    send_level(0, 1'b0, 8);
    #2;
    q0.delete(); q1.delete();
    mdata0 = 8'h00; mdata1 = 8'h00;
    rst = 1'b0;
    #1;
    chk("mid_rst_data", if0.data, 0);
    chk("mid_rst_busy", if0.busy, 0);
    chk("mid_rst_valid", if0.valid, 0);
    chk("mid_rst_data1", if1.data, 0);
    lv0 = 1'b1; if0.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send_level(0, 1'b1, 4);
    send_frame(0, 8'h81, 1'b0, 1'b1, -1, 16);
    chk("post_rst_data_lit", if0.data, 32'h81);
    chk_drained("post_rst_drained");

    // Random frames on both receivers
    for (int n = 0; n < 40; n++) begin
      int         d;
      logic [7:0] w;
      logic       pb;
      logic       st;
      int         g;
      int         gap;
      d   = int'($urandom_range(0, 1));
      w   = 8'($urandom);
      pb  = 1'($urandom);
      st  = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
      g   = int'($urandom_range(0, 9)) - 1;
      gap = int'($urandom_range(0, 6));
      if (!st && gap < 2) gap = 2;
      send_frame(d, w, pb, st, g, 16);
      chk_drained("rand_drained");
      send_level(d, 1'b1, gap);
    end

    send_level(0, 1'b1, 4);
    chk_drained("final_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
